// File: rtl/pipelined_adder_tree.sv
// Pipelined signed reduction tree (one register per level) with valid/ready flow control and a
// post-tree group accumulator. Define ADDER_TREE_SAT_EN for saturating accumulation with out_ovf.

module adder_tree_node #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);
  always_ff @(posedge clk or posedge rst)
    if (rst)     sum <= '0;
    else if (en) sum <= {a[W-1], a} + {b[W-1], b};
endmodule

module pipelined_adder_tree #(
  parameter int N_IN  = 16,
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_ovf
);
  localparam int LEVELS = $clog2(N_IN);
  localparam int TW     = IN_W + LEVELS;

  if (N_IN < 2 || (1 << LEVELS) != N_IN) begin : g_chk_n
    $error("N_IN must be a power of 2 and >= 2");
  end
  if (OUT_W < TW) begin : g_chk_w
    $error("OUT_W must be >= IN_W + clog2(N_IN)");
  end

  logic              stall;
  logic [LEVELS:1]   vld_r, last_r;
  logic [LEVELS:0]   vld_pipe, last_pipe;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign vld_pipe  = {vld_r, in_valid};
  assign last_pipe = {last_r, in_last};

  // Bubbles travel with the beats; everything freezes on a stall.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_r  <= '0;
      last_r <= '0;
    end else if (!stall) begin
      vld_r  <= vld_pipe[LEVELS-1:0];
      last_r <= last_pipe[LEVELS-1:0];
    end

  for (genvar k = 0; k <= LEVELS; k++) begin : lvl
    localparam int NO = N_IN >> k;
    localparam int W  = IN_W + k;
    logic [NO*W-1:0] q;
    if (k == 0) begin : g_in
      assign q = in_data;
    end else begin : g_add
      for (genvar i = 0; i < NO; i++) begin : g_node
        adder_tree_node #(.W(W-1)) u_node (
          .clk (clk),
          .rst (rst),
          .en  (!stall && vld_pipe[k-1]),
          .a   (lvl[k-1].q[2*i*(W-1) +: W-1]),
          .b   (lvl[k-1].q[(2*i+1)*(W-1) +: W-1]),
          .sum (q[i*W +: W])
        );
      end
    end
  end

  logic signed [TW-1:0]    tree;
  logic signed [OUT_W-1:0] tree_ext, acc, nxt;

  assign tree     = lvl[LEVELS].q;
  assign tree_ext = OUT_W'(tree);

`ifdef ADDER_TREE_SAT_EN
  logic signed [OUT_W:0] wide;
  logic                  sat, ovf_acc;

  assign wide = (OUT_W+1)'(acc) + (OUT_W+1)'(tree_ext);
  assign sat  = wide[OUT_W] ^ wide[OUT_W-1];

  always_comb begin
    nxt = wide[OUT_W-1:0];
    if (sat) nxt = wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_acc <= 1'b0;
      out_ovf <= 1'b0;
    end else if (!stall && vld_pipe[LEVELS]) begin
      if (last_pipe[LEVELS]) begin
        out_ovf <= ovf_acc | sat;
        ovf_acc <= 1'b0;
      end else begin
        ovf_acc <= ovf_acc | sat;
      end
    end
`else
  assign nxt     = acc + tree_ext;
  assign out_ovf = 1'b0;
`endif

  // A closing beat publishes the group sum and restarts acc in the same cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (vld_pipe[LEVELS]) begin
        if (last_pipe[LEVELS]) begin
          out_data  <= nxt;
          out_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= nxt;
        end
      end
    end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: directed group/stall/reset cases plus random traffic,
// and a narrow OUT_W=20 instance for the wrap/saturation corner.

module tb_pipelined_adder_tree;
  localparam int N = 16, IW = 16, OW = 32, SW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*IW-1:0] in_data;
  logic            in_last, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [OW-1:0]   out_data;
  logic            in_last2, in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2;
  logic [SW-1:0]   out_data2;

  pipelined_adder_tree #(.N_IN(N), .IN_W(IW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf));

  pipelined_adder_tree #(.N_IN(N), .IN_W(IW), .OUT_W(SW)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_ovf(out_ovf2));

  int            n_chk = 0, n_fail = 0, n_out = 0, n_stall = 0;
  int            exp_q[$];
  longint        acc_m = 0;
  logic [OW-1:0] last_out = '0, prev_data = '0;
  bit            prev_stall = 1'b0, rnd_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [N*IW-1:0] fill(input int v);
    logic [N*IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = IW'(v);
    return r;
  endfunction

  function automatic logic [N*IW-1:0] rand_vec();
    logic [N*IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = IW'($urandom);
    return r;
  endfunction

  // Reference: a group sum is the plain sum of every operand of every beat, wrapped to 32 bits.
  task automatic model(input logic [N*IW-1:0] d, input bit last);
    longint t = 0;
    for (int i = 0; i < N; i++) t += longint'($signed(d[i*IW +: IW]));
    acc_m = longint'(int'(acc_m + t));
    if (last) begin
      exp_q.push_back(int'(acc_m));
      acc_m = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [N*IW-1:0] d, input bit last);
    bit ok = 1'b0;
    in_data = d; in_last = last; in_valid = 1'b1;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end else begin
      model(d, last);
    end
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = rand_vec();
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; acc_m = 0; exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: handshake rule, hold-while-stalled, and in-order scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_in_ready", in_ready, 1);
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (!in_ready) n_stall++;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_out = out_data;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output", $signed(out_data));
        end else begin : pop
          int e;
          e = exp_q.pop_front();
          chk("out_data", longint'($signed(out_data)), longint'(e));
          chk("out_ovf", out_ovf, 0);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_last2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: latency and pulse width
    send(fill(1), 1'b1);
    begin : t1
      int n = 0;
      while (n < 20 && !out_valid) begin @(negedge clk); n++; end
      chk("t1_latency", n, 5);
      @(negedge clk);
      chk("t1_width", out_valid, 0);
      @(posedge clk); #1;
    end
    drain();
    chk("t1_sum", longint'($signed(last_out)), 16);

    // 2: most negative operands, alternating signs
    send(fill(-32768), 1'b1);
    drain();
    chk("t2_min_sum", longint'($signed(last_out)), -524288);
    begin : t2
      logic [N*IW-1:0] v;
      for (int i = 0; i < N; i++) v[i*IW +: IW] = (i % 2) ? IW'(-1) : IW'(1);
      send(v, 1'b1);
    end
    drain();
    chk("t2_alt_sum", longint'($signed(last_out)), 0);

    // 3: multi-beat group then single-beat group
    send(fill(100), 1'b0);
    send(fill(100), 1'b0);
    send(fill(100), 1'b1);
    drain();
    chk("t3_group_sum", longint'($signed(last_out)), 4800);
    send(fill(2), 1'b1);
    drain();
    chk("t3_next_group", longint'($signed(last_out)), 32);

    // 4: back-to-back groups with a 3-cycle downstream stall
    n_stall = 0;
    begin : t4
      int base;
      base = n_out;
      fork
        for (int v = 1; v <= 8; v++) send(fill(v), 1'b1);
        begin
          repeat (7) @(posedge clk);
          #1 out_ready = 1'b0;
          repeat (3) @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join
      drain();
      chk("t4_out_count", n_out - base, 8);
    end
    chk("t4_stall_cycles", n_stall, 3);
    chk("t4_last_sum", longint'($signed(last_out)), 128);

    // 5: reset discards a partial group
    send(fill(50), 1'b0);
    send(fill(50), 1'b0);
    do_reset();
    begin : t5
      int base;
      base = n_out;
      send(fill(1), 1'b1);
      drain();
      chk("t5_out_count", n_out - base, 1);
    end
    chk("t5_sum", longint'($signed(last_out)), 16);

    // 6: narrow accumulator overflow
    begin : t6
      longint a = 0;
      longint t = 16 * 32767;
      bit     ov = 1'b0;
      int     n = 0;
      for (int b = 0; b < 2; b++) begin
        a += t;
`ifdef ADDER_TREE_SAT_EN
        if (a > 524287) begin a = 524287; ov = 1'b1; end
`else
        a = longint'($signed(SW'(a)));
`endif
      end
      in_data = fill(32767); in_valid2 = 1'b1; in_last2 = 1'b0;
      @(posedge clk); #1;
      in_last2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0; in_last2 = 1'b0;
      while (n < 20 && !out_valid2) begin @(negedge clk); n++; end
      chk("t6_valid", out_valid2, 1);
      chk("t6_sum", longint'($signed(out_data2)), a);
      chk("t6_ovf", out_ovf2, ov);
      @(posedge clk); #1;
    end

    // random traffic with random backpressure and idle gaps
    fork
      begin
        for (int b = 0; b < 150; b++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(rand_vec(), ($urandom_range(0, 2) == 0) || (b == 149));
        end
        rnd_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000 && !rnd_done; c++) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
